// File: rtl/lcd1602_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd1602_refresh_ctrl
// Purpose  : Drives an HD44780-compatible 16x2 character LCD over its 8-bit
//            parallel bus.
//            - After reset it waits, then sends the init command sequence.
//            - On each update request it snapshots both text rows and streams
//              34 bytes: the line-1 address, 16 characters, the line-2
//              address and 16 characters.
// Ports    : clk       - system clock
//            nRst      - synchronous active-low reset
//            row1/row2 - 128-bit row text, [127:120] = column 0 (ASCII)
//            update    - single-cycle refresh request
//            busy      - high during init and during a refresh
//            lcd_rs    - 0 = command, 1 = data
//            lcd_rw    - always 0 (write only)
//            lcd_en    - enable strobe
//            lcd_data  - 8-bit data bus
// Revision : 1.0 - initial release
// ============================================================================
module lcd1602_refresh_ctrl #(
  parameter int unsigned POWERUP_CYCLES = 240000,
  parameter int unsigned EN_CYCLES      = 12,
  parameter int unsigned WAIT_CYCLES    = 600,
  parameter int unsigned CLEAR_CYCLES   = 24000
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  input  logic         update,
  output logic         busy,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data
);

  // One counter serves every timed interval, so it is sized for the longest.
  localparam int unsigned MAX_AB  = (POWERUP_CYCLES > EN_CYCLES)   ? POWERUP_CYCLES : EN_CYCLES;
  localparam int unsigned MAX_CD  = (WAIT_CYCLES    > CLEAR_CYCLES) ? WAIT_CYCLES    : CLEAR_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int          CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WT_LAST  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  // Top-level controller states
  localparam logic [1:0] ST_POWERUP = 2'd0;
  localparam logic [1:0] ST_INIT    = 2'd1;
  localparam logic [1:0] ST_IDLE    = 2'd2;
  localparam logic [1:0] ST_REFRESH = 2'd3;

  // Byte engine phases
  localparam logic [1:0] BE_SETUP  = 2'd0;
  localparam logic [1:0] BE_STROBE = 2'd1;
  localparam logic [1:0] BE_SETTLE = 2'd2;

  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;
  localparam logic [7:0] CMD_CLEAR = 8'h01;

  logic [1:0]       state_q, state_d;
  logic [1:0]       eng_q, eng_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             busy_q, busy_d;
  logic             rs_q, rs_d;
  logic             rw_q;
  logic             en_q, en_d;
  logic [7:0]       data_q, data_d;
  logic [127:0]     snap1_q, snap1_d;
  logic [127:0]     snap2_q, snap2_d;

  logic             start_ref;
  logic [CNT_W-1:0] settle_last;
  logic             last_byte;

  // Init command ROM: function set, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return CMD_CLEAR;
      default: return 8'h06;
    endcase
  endfunction

  // Column 0 sits in the top byte, so column c is found 15-c bytes up.
  function automatic logic [7:0] col_byte(input logic [127:0] row, input logic [3:0] col);
    return 8'(row >> {~col, 3'b000});
  endfunction

  // The clear command needs a much longer settle time than other bytes.
  assign settle_last = (state_q == ST_INIT && data_q == CMD_CLEAR) ? CLR_LAST : WT_LAST;
  assign last_byte   = (state_q == ST_INIT) ? (idx_q == 6'd3) : (idx_q == 6'd33);

  always_comb begin
    state_d   = state_q;
    eng_d     = eng_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    rs_d      = rs_q;
    en_d      = en_q;
    data_d    = data_q;
    snap1_d   = snap1_q;
    snap2_d   = snap2_q;
    start_ref = 1'b0;

    // Requests arriving while busy coalesce into one pending refresh.
    if (update && state_q != ST_IDLE) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_POWERUP: begin
        if (cnt_q == PU_LAST) begin
          state_d = ST_INIT;
          eng_d   = BE_SETUP;
          cnt_d   = '0;
          idx_d   = 6'd0;
          rs_d    = 1'b0;
          data_d  = init_cmd(2'd0);
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        en_d      = 1'b0;
        busy_d    = 1'b0;
        start_ref = update;
      end

      default: begin  // ST_INIT, ST_REFRESH: byte engine active
        case (eng_q)
          BE_SETUP: begin
            eng_d = BE_STROBE;
            en_d  = 1'b1;
            cnt_d = '0;
          end

          BE_STROBE: begin
            if (cnt_q == EN_LAST) begin
              eng_d = BE_SETTLE;
              en_d  = 1'b0;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end

          BE_SETTLE: begin
            if (cnt_q != settle_last) begin
              cnt_d = cnt_q + 1'b1;
            end else if (!last_byte) begin
              eng_d = BE_SETUP;
              cnt_d = '0;
              idx_d = idx_q + 6'd1;
              if (state_q == ST_INIT) begin
                rs_d   = 1'b0;
                data_d = init_cmd(idx_q[1:0] + 2'd1);
              end else if (idx_q == 6'd16) begin
                rs_d   = 1'b0;
                data_d = CMD_LINE2;
              end else if (idx_q < 6'd16) begin
                rs_d   = 1'b1;
                data_d = col_byte(snap1_q, idx_q[3:0]);
              end else begin
                // Bytes 18..33 map to row-2 columns 0..15, i.e. idx-17.
                rs_d   = 1'b1;
                data_d = col_byte(snap2_q, idx_q[3:0] - 4'd1);
              end
            end else if (pending_q || update) begin
              // Back-to-back refresh: busy never drops.
              start_ref = 1'b1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              cnt_d   = '0;
            end
          end

          default: begin
            eng_d = BE_SETUP;
            cnt_d = '0;
          end
        endcase
      end
    endcase

    if (start_ref) begin
      snap1_d   = row1;
      snap2_d   = row2;
      state_d   = ST_REFRESH;
      eng_d     = BE_SETUP;
      cnt_d     = '0;
      idx_d     = 6'd0;
      rs_d      = 1'b0;
      data_d    = CMD_LINE1;
      en_d      = 1'b0;
      busy_d    = 1'b1;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q   <= ST_POWERUP;
      eng_q     <= BE_SETUP;
      cnt_q     <= '0;
      idx_q     <= 6'd0;
      pending_q <= 1'b0;
      busy_q    <= 1'b1;
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      en_q      <= 1'b0;
      data_q    <= 8'h00;
      snap1_q   <= '0;
      snap2_q   <= '0;
    end else begin
      state_q   <= state_d;
      eng_q     <= eng_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      rs_q      <= rs_d;
      rw_q      <= 1'b0;
      en_q      <= en_d;
      data_q    <= data_d;
      snap1_q   <= snap1_d;
      snap2_q   <= snap2_d;
    end
  end

  assign busy     = busy_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = rw_q;
  assign lcd_en   = en_q;
  assign lcd_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd1602_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd1602_refresh_ctrl
// Purpose  : Self-checking bench for lcd1602_refresh_ctrl. A monitor records
//            every enable pulse (rs/data, start cycle, width); a reference
//            model builds the byte stream the LCD should receive, and the
//            recorded pulses are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd1602_refresh_ctrl;

  localparam int PU  = 10;
  localparam int EN  = 2;
  localparam int WT  = 3;
  localparam int CLR = 8;
  localparam int PER = 1 + EN + WT;
  localparam int INIT_TIME = PU + 3 * PER + (1 + EN + CLR);
  localparam int REF_TIME  = 34 * PER;

  logic         clk = 1'b0;
  logic         nRst;
  logic [127:0] row1, row2;
  logic         update;
  logic         busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]   lcd_data;

  lcd1602_refresh_ctrl #(
    .POWERUP_CYCLES(PU),
    .EN_CYCLES(EN),
    .WAIT_CYCLES(WT),
    .CLEAR_CYCLES(CLR)
  ) u_dut (
    .clk(clk),
    .nRst(nRst),
    .row1(row1),
    .row2(row2),
    .update(update),
    .busy(busy),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_en(lcd_en),
    .lcd_data(lcd_data)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_d[$];
  int         got_t[$];
  int         got_w[$];

  // Pulse monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic prev_en;
    int   hi;
    prev_en = 1'b0;
    hi      = 0;
    forever begin
      @(negedge clk);
      if (lcd_en && !prev_en) begin
        got_d.push_back({lcd_rs, lcd_data});
        got_t.push_back(cyc);
        hi = 1;
      end else if (lcd_en) begin
        hi++;
      end
      if (!lcd_en && prev_en) got_w.push_back(hi);
      prev_en = lcd_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_d.delete();
    got_t.delete();
    got_w.delete();
    exp_q.delete();
  endtask

  // Reference model: what the LCD should see.
  task automatic model_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic model_refresh(input logic [127:0] r1, input logic [127:0] r2);
    exp_q.push_back({1'b0, 8'h80});
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, r1[127-8*c -: 8]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, r2[127-8*c -: 8]});
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_count"}, got_d.size(), exp_q.size());
    n = (got_d.size() < exp_q.size()) ? got_d.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), got_d[i], exp_q[i]);
      if (i < got_w.size()) check($sformatf("%s_width%0d", tag, i), got_w[i], EN);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), got_t[i] - got_t[i-1],
                       (exp_q[i-1] == 9'h001) ? (1 + EN + CLR) : PER);
    end
  endtask

  task automatic wait_busy_low(input int bound, output int t);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    t = cyc;
    check("busy_fall", busy, 0);
  endtask

  function automatic logic [127:0] rand_row();
    logic [127:0] r;
    for (int c = 0; c < 16; c++) r[8*c +: 8] = 8'($urandom_range(32, 126));
    return r;
  endfunction

  // Pulses update, returns the cycle of the accepting edge.
  task automatic pulse_update(output int tu);
    update = 1'b1;
    tick();
    update = 1'b0;
    tu = cyc;
  endtask

  initial begin
    int t0, t, tu, dummy;
    logic [127:0] a1, a2, b1, b2;

    nRst = 1'b0; update = 1'b0; row1 = '0; row2 = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", busy, 1);
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_data", lcd_data, 0);

    // Power-up and init sequence
    t0 = cyc;
    nRst = 1'b1;
    clear_got();
    model_init();
    wait_busy_low(500, t);
    check("init_time", t - t0, INIT_TIME);
    compare_stream("init");
    if (got_t.size() > 0) check("init_first_en", got_t[0] - t0, PU + 1);

    // HANGMAN refresh; row1 rewritten right after acceptance
    row1 = {"HANGMAN", {9{8'h20}}};
    row2 = {{10{8'h5F}}, {6{8'h20}}};
    repeat (3) tick();
    clear_got();
    model_refresh(row1, row2);
    pulse_update(tu);
    row1 = {16{8'h41}};
    check("ref_busy_rise", busy, 1);
    wait_busy_low(1000, t);
    check("ref_time", t - tu, REF_TIME);
    compare_stream("hangman");
    check("rw_low", lcd_rw, 0);

    // Random refreshes with random rewrites after acceptance
    for (int k = 0; k < 4; k++) begin
      row1 = rand_row();
      row2 = rand_row();
      repeat ($urandom_range(1, 8)) tick();
      clear_got();
      model_refresh(row1, row2);
      pulse_update(tu);
      repeat ($urandom_range(0, 3)) tick();
      row1 = rand_row();
      row2 = rand_row();
      wait_busy_low(1000, t);
      check($sformatf("rand%0d_time", k), t - tu, REF_TIME);
      compare_stream($sformatf("rand%0d", k));
    end

    // Three updates during a refresh coalesce into one back-to-back refresh
    a1 = rand_row(); a2 = rand_row(); b1 = rand_row(); b2 = rand_row();
    row1 = a1; row2 = a2;
    tick();
    clear_got();
    model_refresh(a1, a2);
    model_refresh(b1, b2);
    pulse_update(tu);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(5, 50)) tick();
      pulse_update(dummy);
    end
    while (cyc < tu + 180) tick();
    row1 = b1; row2 = b2;
    wait_busy_low(2000, t);
    check("coalesce_time", t - tu, 2 * REF_TIME);
    compare_stream("coalesce");

    // update in the final settle cycle counts as pending
    a1 = rand_row(); a2 = rand_row(); b1 = rand_row(); b2 = rand_row();
    row1 = a1; row2 = a2;
    tick();
    clear_got();
    model_refresh(a1, a2);
    model_refresh(b1, b2);
    pulse_update(tu);
    while (cyc < tu + REF_TIME - 1) tick();
    row1 = b1; row2 = b2;
    pulse_update(dummy);
    check("lastcyc_busy", busy, 1);
    wait_busy_low(1000, t);
    check("lastcyc_time", t - tu, 2 * REF_TIME);
    compare_stream("lastcyc");

    // Reset in the strobe of byte 5, with a pending request outstanding
    row1 = rand_row(); row2 = rand_row();
    tick();
    clear_got();
    pulse_update(tu);
    repeat (20) tick();
    pulse_update(dummy);
    t = 0;
    while (got_d.size() < 5 && t < 200) begin
      tick();
      t++;
    end
    check("midrst_en_high", lcd_en, 1);
    nRst = 1'b0;
    tick();
    check("midrst_en", lcd_en, 0);
    check("midrst_busy", busy, 1);
    check("midrst_data", lcd_data, 0);
    check("midrst_rs", lcd_rs, 0);
    t0 = cyc;
    nRst = 1'b1;
    clear_got();
    model_init();
    wait_busy_low(500, t);
    check("midrst_init_time", t - t0, INIT_TIME);
    repeat (60) tick();
    check("midrst_idle_busy", busy, 0);
    compare_stream("midrst");

    // update during POWERUP is serviced straight after INIT
    nRst = 1'b0;
    tick();
    t0 = cyc;
    nRst = 1'b1;
    clear_got();
    row1 = rand_row(); row2 = rand_row();
    model_init();
    model_refresh(row1, row2);
    repeat (3) tick();
    pulse_update(dummy);
    wait_busy_low(2000, t);
    check("pu_upd_time", t - t0, INIT_TIME + REF_TIME);
    compare_stream("pu_upd");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
